// File: rtl/neg_zero_sched.sv
// Round-robin scheduler that shares a negate / bit-flip / nonzero-test datapath
// between two requesters, with one operation in flight at a time.
//
// state | meaning
// IDLE  | waiting for a request; grant logic active
// NEG   | two's-complement negate of the operand
// FLIP  | invert operand bit FLIP_BIT
// RESP  | result presented until the consumer takes it
module neg_zero_sched #(
    parameter int               WIDTH           = 29,
    parameter logic [WIDTH-1:0] DEFAULT_OPERAND = 29'h00000F93,
    parameter int               FLIP_BIT        = 2
) (
    input  logic             clock_4,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [1:0]       req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [1:0]       req1_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_value,
    output logic             rsp_flag,
    output logic             busy,
    output logic [7:0]       op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NEG  = 2'd1,
        FLIP = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] operand;
    logic             last_grant;
    logic             grant0;
    logic             grant1;

    // On contention the requester that was not served last wins.
    assign grant0 = req0_valid & (~req1_valid | last_grant);
    assign grant1 = req1_valid & (~req0_valid | ~last_grant);
    assign busy   = (state != IDLE);

    always_ff @(posedge clock_4 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        rsp_value  = '0;
        rsp_flag   = 1'b0;
        case (state)
            IDLE: begin
                // Gated by reset_n so no handshake is advertised while reset is held.
                req0_ready = reset_n & grant0;
                req1_ready = reset_n & grant1;
                if (grant0 | grant1) begin
                    state_nxt = NEG;
                end
            end
            NEG:  state_nxt = FLIP;
            FLIP: state_nxt = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                rsp_value = operand;
                rsp_flag  = |operand;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock_4 or negedge reset_n) begin
        if (!reset_n) begin
            operand    <= '0;
            rsp_id     <= 1'b0;
            last_grant <= 1'b1;
            op_count   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0) begin
                        operand    <= (|req0_sel) ? req0_data : DEFAULT_OPERAND;
                        rsp_id     <= 1'b0;
                        last_grant <= 1'b0;
                    end else if (grant1) begin
                        operand    <= (|req1_sel) ? req1_data : DEFAULT_OPERAND;
                        rsp_id     <= 1'b1;
                        last_grant <= 1'b1;
                    end
                end
                NEG:  operand <= ~operand + {{(WIDTH-1){1'b0}}, 1'b1};
                FLIP: operand[FLIP_BIT] <= ~operand[FLIP_BIT];
                RESP: begin
                    if (rsp_ready && (op_count != 8'hFF)) begin
                        op_count <= op_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neg_zero_sched.sv
// Directed bench for neg_zero_sched: vector table of single operations plus
// hand-written sequences for fairness, backpressure, mid-op reset and saturation.
module tb_neg_zero_sched;

    logic        clock_4;
    logic        reset_n;
    logic        req0_valid, req0_ready;
    logic [28:0] req0_data;
    logic [1:0]  req0_sel;
    logic        req1_valid, req1_ready;
    logic [28:0] req1_data;
    logic [1:0]  req1_sel;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_flag, busy;
    logic [28:0] rsp_value;
    logic [7:0]  op_count;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_count = 0;

    neg_zero_sched dut (
        .clock_4   (clock_4),
        .reset_n   (reset_n),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_data (req0_data),
        .req0_sel  (req0_sel),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_data (req1_data),
        .req1_sel  (req1_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_value (rsp_value),
        .rsp_flag  (rsp_flag),
        .busy      (busy),
        .op_count  (op_count)
    );

    initial clock_4 = 1'b0;
    always #5 clock_4 = ~clock_4;

    typedef struct {
        logic        req;
        logic [1:0]  sel;
        logic [28:0] data;
        logic [28:0] ev;
        logic        ef;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_req(input logic r, input logic v, input logic [1:0] s, input logic [28:0] d);
        if (r == 1'b0) begin
            req0_valid = v; req0_sel = s; req0_data = d;
        end else begin
            req1_valid = v; req1_sel = s; req1_data = d;
        end
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        rsp_ready = 1'b1;
        drive_req(1'b0, 1'b1, 2'b01, 29'h1);
        drive_req(1'b1, 1'b1, 2'b01, 29'h2);
        repeat (2) @(posedge clock_4);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        chk("rst_value", 32'(rsp_value), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        drive_req(1'b0, 1'b0, 2'b00, 29'h0);
        drive_req(1'b1, 1'b0, 2'b00, 29'h0);
        @(negedge clock_4);
        reset_n   = 1'b1;
        exp_count = 0;
    endtask

    // One complete operation with rsp_ready high; checks latency and result.
    task automatic run_op(input logic r, input logic [1:0] s, input logic [28:0] d,
                          input logic [28:0] ev, input logic ef);
        int n;
        @(negedge clock_4);
        rsp_ready = 1'b1;
        drive_req(r, 1'b1, s, d);
        #1;
        n = 0;
        while (!(r ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clock_4);
            #1;
            n++;
        end
        if (n >= 20) begin
            chk("accept_timeout", 32'(n), 32'd0);
            drive_req(r, 1'b0, 2'b00, 29'h0);
            return;
        end
        @(posedge clock_4);
        #1;
        drive_req(r, 1'b0, 2'b00, 29'($urandom));
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("lat_edge1", 32'(rsp_valid), 32'd0);
        @(posedge clock_4);
        #1;
        chk("lat_edge2", 32'(rsp_valid), 32'd0);
        @(posedge clock_4);
        #1;
        chk("lat_edge3", 32'(rsp_valid), 32'd1);
        chk("rsp_id", 32'(rsp_id), 32'(r));
        chk("rsp_value", 32'(rsp_value), 32'(ev));
        chk("rsp_flag", 32'(rsp_flag), 32'(ef));
        @(posedge clock_4);
        #1;
        if (exp_count < 255) exp_count++;
        chk("op_count", 32'(op_count), 32'(exp_count));
        chk("idle_after_rsp", 32'(busy), 32'd0);
    endtask

    initial begin
        int k, cyc, hs;
        int order[4];
        int acc_cyc[4];

        vecs[0] = '{req: 1'b0, sel: 2'b00, data: 29'h00ABCDEF, ev: 29'h1FFFF069, ef: 1'b1};
        vecs[1] = '{req: 1'b1, sel: 2'b10, data: 29'h1FFFFFFC, ev: 29'h00000000, ef: 1'b0};
        vecs[2] = '{req: 1'b0, sel: 2'b01, data: 29'h00000000, ev: 29'h00000004, ef: 1'b1};
        vecs[3] = '{req: 1'b1, sel: 2'b11, data: 29'h00000001, ev: 29'h1FFFFFFB, ef: 1'b1};
        vecs[4] = '{req: 1'b1, sel: 2'b00, data: 29'h00001234, ev: 29'h1FFFF069, ef: 1'b1};
        vecs[5] = '{req: 1'b0, sel: 2'b10, data: 29'h10000000, ev: 29'h10000004, ef: 1'b1};

        req0_valid = 0; req0_sel = 0; req0_data = 0;
        req1_valid = 0; req1_sel = 0; req1_data = 0;
        rsp_ready  = 1;
        do_reset();

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].req, vecs[i].sel, vecs[i].data, vecs[i].ev, vecs[i].ef);
        end

        // Fairness: both requesters held valid for four operations.
        do_reset();
        @(negedge clock_4);
        drive_req(1'b0, 1'b1, 2'b00, 29'h0);
        drive_req(1'b1, 1'b1, 2'b00, 29'h0);
        k = 0;
        cyc = 0;
        while (k < 4 && cyc < 40) begin
            #1;
            chk("one_ready", 32'(req0_ready & req1_ready), 32'd0);
            if (req0_ready | req1_ready) begin
                order[k]   = req1_ready ? 1 : 0;
                acc_cyc[k] = cyc;
                k++;
            end
            @(negedge clock_4);
            cyc++;
        end
        chk("fair_accepts", 32'(k), 32'd4);
        drive_req(1'b0, 1'b0, 2'b00, 29'h0);
        drive_req(1'b1, 1'b0, 2'b00, 29'h0);
        if (k == 4) begin
            for (int i = 0; i < 4; i++) chk("fair_order", 32'(order[i]), 32'(i % 2));
            for (int i = 0; i < 3; i++) chk("fair_spacing", 32'(acc_cyc[i+1] - acc_cyc[i]), 32'd4);
        end
        repeat (6) @(posedge clock_4);
        #1;
        chk("fair_op_count", 32'(op_count), 32'd4);
        exp_count = 4;

        // Backpressure: hold RESP for five cycles while req1 waits.
        @(negedge clock_4);
        rsp_ready = 1'b0;
        drive_req(1'b0, 1'b1, 2'b01, 29'h00000123);
        #1;
        chk("bp_accept", 32'(req0_ready), 32'd1);
        @(posedge clock_4);
        #1;
        drive_req(1'b0, 1'b0, 2'b00, 29'h0);
        drive_req(1'b1, 1'b1, 2'b00, 29'h0);
        repeat (2) begin
            chk("bp_stall_ready", 32'(req1_ready), 32'd0);
            @(posedge clock_4);
            #1;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_value", 32'(rsp_value), 32'h1FFFFED9);
            chk("bp_flag", 32'(rsp_flag), 32'd1);
            chk("bp_stall_ready", 32'(req1_ready), 32'd0);
            @(posedge clock_4);
            #1;
        end
        rsp_ready = 1'b1;
        drive_req(1'b1, 1'b0, 2'b00, 29'h0);
        @(posedge clock_4);
        #1;
        chk("bp_op_count", 32'(op_count), 32'd5);
        chk("bp_idle", 32'(busy), 32'd0);

        // Reset pulse during FLIP discards the operation.
        drive_req(1'b1, 1'b1, 2'b10, 29'h00000055);
        #1;
        chk("mr_accept", 32'(req1_ready), 32'd1);
        @(posedge clock_4);
        #1;
        drive_req(1'b1, 1'b0, 2'b00, 29'h0);
        @(posedge clock_4);
        #1;
        chk("mr_busy_flip", 32'(busy), 32'd1);
        drive_req(1'b0, 1'b1, 2'b00, 29'h0);
        drive_req(1'b1, 1'b1, 2'b00, 29'h0);
        reset_n = 1'b0;
        #1;
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_op_count", 32'(op_count), 32'd0);
        chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mr_ready0", 32'(req0_ready), 32'd0);
        chk("mr_ready1", 32'(req1_ready), 32'd0);
        #1;
        reset_n = 1'b1;
        #1;
        chk("mr_grant0", 32'(req0_ready), 32'd1);
        chk("mr_grant1", 32'(req1_ready), 32'd0);
        @(posedge clock_4);
        #1;
        drive_req(1'b0, 1'b0, 2'b00, 29'h0);
        drive_req(1'b1, 1'b0, 2'b00, 29'h0);
        chk("mr_no_rsp", 32'(rsp_valid), 32'd0);
        @(posedge clock_4);
        #1;
        chk("mr_no_rsp", 32'(rsp_valid), 32'd0);
        @(posedge clock_4);
        #1;
        chk("mr_rsp_valid2", 32'(rsp_valid), 32'd1);
        chk("mr_rsp_id", 32'(rsp_id), 32'd0);
        chk("mr_rsp_value", 32'(rsp_value), 32'h1FFFF069);
        @(posedge clock_4);
        #1;
        chk("mr_op_count2", 32'(op_count), 32'd1);

        // Saturation: 260 back-to-back operations from req0.
        do_reset();
        @(negedge clock_4);
        rsp_ready = 1'b1;
        drive_req(1'b0, 1'b1, 2'b00, 29'h0);
        hs = 0;
        cyc = 0;
        while (hs < 260 && cyc < 2000) begin
            @(negedge clock_4);
            cyc++;
            if (rsp_valid) begin
                chk("sat_running", 32'(op_count), 32'((hs < 255) ? hs : 255));
                hs++;
            end
        end
        chk("sat_handshakes", 32'(hs), 32'd260);
        drive_req(1'b0, 1'b0, 2'b00, 29'h0);
        @(posedge clock_4);
        #1;
        chk("sat_final", 32'(op_count), 32'd255);
        repeat (10) @(posedge clock_4);
        #1;
        chk("sat_hold", 32'(op_count), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/neg_zero_sched.md
Name: neg_zero_sched

Overview:
- Round-robin scheduler that shares one multi-cycle datapath between two requesters. The datapath performs a negate, then a single-bit flip, then a nonzero test.
- Per request: operand select (requester data, or DEFAULT_OPERAND when the select field is zero) → two's-complement negate → invert bit FLIP_BIT → reduction-OR flag.
- Sits between operand producers and a single response consumer. Only one operation is in flight at a time.

Parameters:
WIDTH, 29, operand/result width in bits
DEFAULT_OPERAND, 29'h00000F93, operand used when the request select field is 2'b00
FLIP_BIT, 2, result bit index inverted after negation (must be < WIDTH)

Ports:
clock_4  input  1  sole clock, rising edge
reset_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 accepted this cycle
req0_data  input  WIDTH  requester 0 operand
req0_sel  input  2  requester 0 select; nonzero uses req0_data, zero uses DEFAULT_OPERAND
req1_valid  input  1  requester 1 has an operation
req1_ready  output  1  requester 1 accepted this cycle
req1_data  input  WIDTH  requester 1 operand
req1_sel  input  2  requester 1 select, same rule as req0_sel
rsp_valid  output  1  response available
rsp_ready  input  1  consumer takes response
rsp_id  output  1  requester index of the response
rsp_value  output  WIDTH  datapath result
rsp_flag  output  1  |rsp_value
busy  output  1  state != IDLE
op_count  output  8  completed responses, saturating

Behaviour:
- Reset (reset_n low, asynchronous):
  - FSM goes to IDLE; operand register and rsp_id clear to 0; op_count clears to 0; last_grant is set to 1, so req0 wins first.
  - While reset_n is low: rsp_valid=0, busy=0, req0_ready=0, req1_ready=0, rsp_value=0, rsp_flag=0.
- FSM states: IDLE → NEG → FLIP → RESP → IDLE.
- IDLE:
  - Grant logic is combinational.
  - If only one valid is high, that requester is granted.
  - If both are high, the requester other than last_grant is granted.
  - reqN_ready = (state==IDLE) & granted & reqN_valid. At most one ready is high in any cycle.
  - Accept edge (valid&ready):
    - operand register <= (|sel) ? data : DEFAULT_OPERAND
    - rsp_id <= N
    - last_grant <= N
    - state <= NEG
  - If no valid is high, stay in IDLE; last_grant is unchanged.
- NEG: operand <= (~operand + 1) mod 2^WIDTH (the carry out is discarded); state <= FLIP.
- FLIP: operand[FLIP_BIT] <= ~operand[FLIP_BIT]; all other bits are held; state <= RESP.
- RESP:
  - Outputs: rsp_valid=1, rsp_value=operand, rsp_flag=|operand.
  - Values are held stable until rsp_ready is high.
  - On rsp_valid&rsp_ready: state <= IDLE; op_count increments, holding at 255 once reached.
- Outside RESP, rsp_value and rsp_flag are 0. rsp_ready is ignored outside RESP.
- Latency: rsp_valid rises on the 3rd rising edge after the accept edge. With rsp_ready tied high, the minimum spacing between accepts is 4 cycles.
- Data and select are sampled only on the accept edge. Changes afterwards have no effect.
- A requester may drop valid before it is granted. No state changes in that case.
- New requests are not accepted while busy. Requests stall, and their ready stays 0.
- Reset during NEG, FLIP or RESP:
  - The operation is discarded and no response is issued.
  - op_count is cleared.
  - The first grant after reset goes to req0.
- Zero flag case: rsp_flag=0 only when the negated-and-flipped value is all zero. With defaults this means the operand is 29'h1FFFFFFC.

Test Plan:
- Default operand: req0_valid, req0_sel=0, rsp_ready=1 → rsp_value=29'h1FFFF069, rsp_flag=1, rsp_id=0; rsp_valid 3 edges after accept; op_count=1.
- Zero result: req1_sel=2'b10, req1_data=29'h1FFFFFFC → rsp_value=0, rsp_flag=0, rsp_id=1.
- Zero operand with select: req0_sel=2'b01, req0_data=0 → rsp_value=29'h00000004, rsp_flag=1.
- Fairness: both valid held continuously for 4 operations, rsp_ready=1 → grant order 0,1,0,1; ready never high for both requesters in the same cycle; accepts spaced 4 cycles apart.
- Backpressure and mid-op reset:
  - rsp_ready=0 for 5 cycles in RESP → rsp_value and rsp_flag held; no accepts while busy.
  - Pulse reset_n low during FLIP → no response; busy=0 and op_count=0 immediately.
  - Next simultaneous request after reset → granted to req0.
- Saturation: complete 260 operations → op_count=255 and stays 255.
